// File: rtl/mtrp_bit_decoder_if.sv
// Bus between the MTRP receiver front end and the Manchester bit decoder.
// The receiver side (master) drives the ce strobe and the half-wave
// detections; the decoder side (slave) returns the recovered word, the
// DV/ERR pulses, the measured half-period and the busy flag.
//
// Handshake: there is no ready signal and no backpressure. DV and ERR are
// single-clk pulses, never asserted together; DAT and HT are only
// meaningful as held values and must be captured on the DV pulse.
interface mtrp_bit_decoder_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
);
    logic             ce;
    logic             RXP;
    logic             RXN;
    logic [WIDTH-1:0] DAT;
    logic             DV;
    logic             ERR;
    logic [CW-1:0]    HT;
    logic             BUSY;

    modport master (
        output ce, RXP, RXN,
        input  DAT, DV, ERR, HT, BUSY
    );

    modport slave (
        input  ce, RXP, RXN,
        output DAT, DV, ERR, HT, BUSY
    );
endinterface

// File: rtl/mtrp_bit_decoder.sv
// Manchester bit decoder for the MTRP receiver.
// Measures the half-period on the high half of the start bit, then samples
// each following half-bit open loop in its middle and decodes (P,N)=1,
// (N,P)=0, MSB first. All timing is in ce ticks; nothing advances when ce=0.
// dbg_state exposes the FSM encoding for external checkers.
module mtrp_bit_decoder #(
    parameter int WIDTH = 8,
    parameter int CW    = 8,
    parameter int HMIN  = 3
) (
    input  logic                clk,
    input  logic                res,
    mtrp_bit_decoder_if.slave   bus,
    output logic [2:0]          dbg_state
);

    // Half index runs 0 (start second half) .. 2*WIDTH (last data half).
    localparam int HW = $clog2(2*WIDTH+2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] MEAS   = 3'd1;
    localparam logic [2:0] START2 = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW:0]   ONE_W   = (CW+1)'(1);
    localparam logic [CW-1:0] CNT_TOP = {CW{1'b1}};
    localparam logic [CW-1:0] HMIN_C  = CW'(HMIN);
    localparam logic [HW-1:0] HONE    = HW'(1);
    localparam logic [HW-1:0] LAST_HI = HW'(2*WIDTH);

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    ph;
    logic [HW-1:0]    hi;
    logic [CW-1:0]    dcnt;
    logic [WIDTH-1:0] sreg;
    logic             first_p;
    logic             first_n;
    logic [WIDTH-1:0] dat_q;
    logic             dv_q;
    logic             err_q;
    logic [CW-1:0]    ht_q;

    logic             smp_p;
    logic             smp_n;
    logic             smp_z;
    logic [CW-1:0]    half;
    logic             at_mid;
    logic             at_wrap;
    logic [CW-1:0]    ph_nxt;
    logic [HW-1:0]    hi_nxt;
    logic             code_one;
    logic             code_zero;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CW:0]      dcnt_inc;
    logic             drain_done;

    // Line classification, sample-point timing and bit decode for this tick.
    always_comb begin
        smp_p      = bus.RXP & ~bus.RXN;
        smp_n      = bus.RXN & ~bus.RXP;
        smp_z      = ~(smp_p | smp_n);
        half       = ht_q >> 1;
        at_mid     = (ph == half);
        at_wrap    = (ph == (ht_q - ONE));
        ph_nxt     = at_wrap ? '0 : (ph + ONE);
        hi_nxt     = at_wrap ? (hi + HONE) : hi;
        code_one   = first_p & smp_n;
        code_zero  = first_n & smp_p;
        sreg_nxt   = {sreg[WIDTH-2:0], code_one};
        dcnt_inc   = {1'b0, dcnt} + ONE_W;
        // An HT of 0 (no start accepted yet) still needs one quiet tick.
        drain_done = (dcnt_inc >= {1'b0, ht_q});
    end

    // Frame FSM: measure start, sample mid half-bits, drain until quiet.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= IDLE;
            cnt     <= '0;
            ph      <= '0;
            hi      <= '0;
            dcnt    <= '0;
            sreg    <= '0;
            first_p <= 1'b0;
            first_n <= 1'b0;
            dat_q   <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            ht_q    <= '0;
        end else begin
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            if (bus.ce) begin
                case (state)
                    IDLE: begin
                        if (smp_p) begin
                            cnt   <= ONE;
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (smp_p) begin
                            if (cnt == (CNT_TOP - ONE)) begin
                                // Line stuck high: counter would saturate.
                                err_q <= 1'b1;
                                dcnt  <= '0;
                                state <= DRAIN;
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end else if (cnt < HMIN_C) begin
                            // Too short to be a start bit: glitch.
                            state <= IDLE;
                        end else begin
                            // This tick is t0; ph holds the offset of the next tick.
                            ht_q  <= cnt;
                            ph    <= ONE;
                            hi    <= '0;
                            sreg  <= '0;
                            state <= START2;
                        end
                    end
                    START2: begin
                        if (at_mid && !smp_n) begin
                            err_q <= 1'b1;
                            dcnt  <= '0;
                            state <= DRAIN;
                        end else begin
                            ph <= ph_nxt;
                            hi <= hi_nxt;
                            if (at_wrap) begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (at_mid && hi[0]) begin
                            // First half of a bit: hold the sample for the pair.
                            first_p <= smp_p;
                            first_n <= smp_n;
                            ph      <= ph_nxt;
                            hi      <= hi_nxt;
                        end else if (at_mid) begin
                            if (code_one || code_zero) begin
                                sreg <= sreg_nxt;
                                if (hi == LAST_HI) begin
                                    dat_q <= sreg_nxt;
                                    dv_q  <= 1'b1;
                                    dcnt  <= '0;
                                    state <= DRAIN;
                                end else begin
                                    ph <= ph_nxt;
                                    hi <= hi_nxt;
                                end
                            end else begin
                                err_q <= 1'b1;
                                dcnt  <= '0;
                                state <= DRAIN;
                            end
                        end else begin
                            ph <= ph_nxt;
                            hi <= hi_nxt;
                        end
                    end
                    DRAIN: begin
                        if (smp_z) begin
                            if (drain_done) begin
                                dcnt  <= '0;
                                state <= IDLE;
                            end else begin
                                dcnt <= dcnt + ONE;
                            end
                        end else begin
                            dcnt <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Registered outputs onto the bus.
    always_comb begin
        bus.DAT   = dat_q;
        bus.DV    = dv_q;
        bus.ERR   = err_q;
        bus.HT    = ht_q;
        bus.BUSY  = (state != IDLE);
        dbg_state = state;
    end

endmodule
